// File: rtl/pht_predictor.sv
// Pattern history table branch predictor: bimodal or gshare indexing into
// saturating counters, with a global history register and mispredict counter.
module pht_predictor #(
  parameter int CNT_WIDTH = 2,
  parameter int IDX_BITS  = 6,
  parameter int GHR_BITS  = 6,
  parameter int GSHARE    = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [31:0]         pc_i,
  output logic                predict_taken_o,
  output logic [IDX_BITS-1:0] predict_idx_o,
  input  logic                update_valid_i,
  input  logic [IDX_BITS-1:0] update_idx_i,
  input  logic                update_taken_i,
  input  logic                update_mispredict_i,
  input  logic                flush_hist_i,
  output logic [15:0]         mispredict_cnt_o
);

  localparam int DEPTH = 2 ** IDX_BITS;
  // History register keeps at least one bit so GHR_BITS=0 still elaborates.
  localparam int GW = (GHR_BITS > 0) ? GHR_BITS : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_INIT = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [CNT_WIDTH-1:0] pht_q [DEPTH];
  logic [GW-1:0]        ghr_q;
  logic [IDX_BITS-1:0]  hist_idx;
  logic [CNT_WIDTH-1:0] upd_cur;
  logic [CNT_WIDTH-1:0] upd_next;
  logic                 unused_pc;

  generate
    if (GSHARE != 0 && GHR_BITS > 0) begin : g_gshare
      always_comb begin
        hist_idx         = '0;
        hist_idx[GW-1:0] = ghr_q;
      end
    end else begin : g_bimodal
      logic unused_ghr;
      assign hist_idx   = '0;
      assign unused_ghr = ^ghr_q;
    end
  endgenerate

  assign unused_pc       = ^{pc_i[31:IDX_BITS+2], pc_i[1:0]};
  assign predict_idx_o   = pc_i[IDX_BITS+1:2] ^ hist_idx;
  // Reads the registered table, so a same-cycle update is not bypassed.
  assign predict_taken_o = pht_q[predict_idx_o][CNT_WIDTH-1];

  always_comb begin
    upd_cur  = pht_q[update_idx_i];
    upd_next = upd_cur;
    if (update_taken_i) begin
      if (upd_cur != CNT_MAX) upd_next = upd_cur + CNT_WIDTH'(1);
    end else begin
      if (upd_cur != '0) upd_next = upd_cur - CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) pht_q[i] <= CNT_INIT;
    end else if (update_valid_i) begin
      pht_q[update_idx_i] <= upd_next;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ghr_q <= '0;
    end else if (flush_hist_i) begin
      ghr_q <= '0;
    end else if (update_valid_i) begin
      ghr_q <= GW'({ghr_q, update_taken_i});
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mispredict_cnt_o <= '0;
    end else if (update_valid_i && update_mispredict_i && mispredict_cnt_o != 16'hFFFF) begin
      mispredict_cnt_o <= mispredict_cnt_o + 16'd1;
    end
  end

endmodule

// File: tb/tb_pht_predictor.sv
// Directed self-checking bench for pht_predictor with default parameters.
module tb_pht_predictor;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] pc_i;
  logic        predict_taken_o;
  logic [5:0]  predict_idx_o;
  logic        update_valid_i;
  logic [5:0]  update_idx_i;
  logic        update_taken_i;
  logic        update_mispredict_i;
  logic        flush_hist_i;
  logic [15:0] mispredict_cnt_o;

  int n_cmp  = 0;
  int n_fail = 0;

  pht_predictor dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .pc_i                (pc_i),
    .predict_taken_o     (predict_taken_o),
    .predict_idx_o       (predict_idx_o),
    .update_valid_i      (update_valid_i),
    .update_idx_i        (update_idx_i),
    .update_taken_i      (update_taken_i),
    .update_mispredict_i (update_mispredict_i),
    .flush_hist_i        (flush_hist_i),
    .mispredict_cnt_o    (mispredict_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // One update cycle; inputs return to idle 1 time unit after the edge.
  task automatic upd(input logic [5:0] idx, input logic taken, input logic mis, input logic flush);
    update_valid_i      = 1'b1;
    update_idx_i        = idx;
    update_taken_i      = taken;
    update_mispredict_i = mis;
    flush_hist_i        = flush;
    @(posedge clk_i); #1;
    update_valid_i      = 1'b0;
    update_mispredict_i = 1'b0;
    flush_hist_i        = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    pc_i = 32'h0000_0040;
    update_valid_i = 1'b0; update_idx_i = '0; update_taken_i = 1'b0;
    update_mispredict_i = 1'b0; flush_hist_i = 1'b0;
    #2;
    n_cmp++; if (predict_idx_o !== 6'h10) begin n_fail++; $display("FAIL reset_idx: got %h expected %h", predict_idx_o, 6'h10); end
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b expected 0", predict_taken_o); end
    n_cmp++; if (mispredict_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h expected 0000", mispredict_cnt_o); end
    // Updates presented while in reset must be discarded.
    update_valid_i = 1'b1; update_idx_i = 6'h10; update_taken_i = 1'b1; update_mispredict_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    update_valid_i = 1'b0; update_mispredict_i = 1'b0;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL reset_discard_taken: got %b expected 0", predict_taken_o); end
    n_cmp++; if (mispredict_cnt_o !== 16'h0) begin n_fail++; $display("FAIL reset_discard_cnt: got %h expected 0000", mispredict_cnt_o); end
    n_cmp++; if (predict_idx_o !== 6'h10) begin n_fail++; $display("FAIL reset_discard_ghr: idx got %h expected %h", predict_idx_o, 6'h10); end
  endtask

  // Flush accompanies every update so the history stays zero and pc 0x14 keeps idx 5.
  task automatic test_saturate();
    pc_i = 32'h0000_0014;
    #1;
    n_cmp++; if (predict_idx_o !== 6'h05) begin n_fail++; $display("FAIL sat_idx: got %h expected 05", predict_idx_o); end
    upd(6'd5, 1'b1, 1'b0, 1'b1);  // 01 -> 10
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_up1: got %b expected 1", predict_taken_o); end
    upd(6'd5, 1'b1, 1'b0, 1'b1);  // 10 -> 11
    upd(6'd5, 1'b1, 1'b0, 1'b1);  // 11 stays
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_up3: got %b expected 1", predict_taken_o); end
    n_cmp++; if (predict_idx_o !== 6'h05) begin n_fail++; $display("FAIL sat_flush_prio: idx got %h expected 05", predict_idx_o); end
    upd(6'd5, 1'b0, 1'b0, 1'b1);  // 11 -> 10 (a wrapped 00 would give 0 below)
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_top_hold: got %b expected 1", predict_taken_o); end
    upd(6'd5, 1'b0, 1'b0, 1'b1);  // 10 -> 01
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_down1: got %b expected 0", predict_taken_o); end
    upd(6'd5, 1'b0, 1'b0, 1'b1);  // 01 -> 00
    for (int i = 0; i < 4; i++) begin
      upd(6'd5, 1'b0, 1'b0, 1'b1);  // 00 stays
      n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_floor step %0d: got %b expected 0", i, predict_taken_o); end
    end
    upd(6'd5, 1'b1, 1'b0, 1'b1);  // 00 -> 01
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL sat_floor_up1: got %b expected 0", predict_taken_o); end
    upd(6'd5, 1'b1, 1'b0, 1'b1);  // 01 -> 10
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL sat_floor_up2: got %b expected 1", predict_taken_o); end
  endtask

  task automatic test_ghr();
    pc_i = 32'h0000_0040;
    upd(6'd20, 1'b1, 1'b0, 1'b0);  // ghr 000001
    n_cmp++; if (predict_idx_o !== 6'h11) begin n_fail++; $display("FAIL ghr_1: got %h expected 11", predict_idx_o); end
    upd(6'd21, 1'b1, 1'b0, 1'b0);  // ghr 000011
    n_cmp++; if (predict_idx_o !== 6'h13) begin n_fail++; $display("FAIL ghr_2: got %h expected 13", predict_idx_o); end
    upd(6'd22, 1'b0, 1'b0, 1'b0);  // ghr 000110, counter 22 -> 00
    n_cmp++; if (predict_idx_o !== 6'h16) begin n_fail++; $display("FAIL ghr_3: got %h expected 16", predict_idx_o); end
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL ghr_3_taken: got %b expected 0", predict_taken_o); end
    pc_i = 32'h0000_0000;
    #1;
    n_cmp++; if (predict_idx_o !== 6'h06) begin n_fail++; $display("FAIL ghr_pc0: got %h expected 06", predict_idx_o); end
    // Counter 20 went 01 -> 10; reach it via pc idx 20^6=18 (pc 0x48).
    pc_i = 32'h0000_0048;
    #1;
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL ghr_upd_idx20: got %b expected 1", predict_taken_o); end
  endtask

  task automatic test_same_index();
    pc_i = 32'h0000_0040;
    flush_hist_i = 1'b1;
    @(posedge clk_i); #1;
    flush_hist_i = 1'b0;
    n_cmp++; if (predict_idx_o !== 6'h10) begin n_fail++; $display("FAIL flush_only: got %h expected 10", predict_idx_o); end
    pc_i = 32'h0000_0024;
    update_valid_i = 1'b1; update_idx_i = 6'd9; update_taken_i = 1'b1; flush_hist_i = 1'b1;
    #1;
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL same_idx_old: got %b expected 0", predict_taken_o); end
    @(posedge clk_i); #1;
    update_valid_i = 1'b0; flush_hist_i = 1'b0;
    n_cmp++; if (predict_idx_o !== 6'h09) begin n_fail++; $display("FAIL flush_with_upd: idx got %h expected 09", predict_idx_o); end
    n_cmp++; if (predict_taken_o !== 1'b1) begin n_fail++; $display("FAIL same_idx_new: got %b expected 1", predict_taken_o); end
  endtask

  task automatic test_mispredict();
    update_valid_i = 1'b0; update_mispredict_i = 1'b1;
    @(posedge clk_i); #1;
    update_mispredict_i = 1'b0;
    n_cmp++; if (mispredict_cnt_o !== 16'h0) begin n_fail++; $display("FAIL mis_no_valid: got %h expected 0000", mispredict_cnt_o); end
    update_valid_i = 1'b1; update_idx_i = 6'd63; update_taken_i = 1'b1; update_mispredict_i = 1'b1;
    @(posedge clk_i); #1;
    n_cmp++; if (mispredict_cnt_o !== 16'h0001) begin n_fail++; $display("FAIL mis_one: got %h expected 0001", mispredict_cnt_o); end
    repeat (65533) @(posedge clk_i);
    #1;
    n_cmp++; if (mispredict_cnt_o !== 16'hFFFE) begin n_fail++; $display("FAIL mis_fffe: got %h expected fffe", mispredict_cnt_o); end
    @(posedge clk_i); #1;
    n_cmp++; if (mispredict_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL mis_ffff: got %h expected ffff", mispredict_cnt_o); end
    repeat (70000 - 65535) @(posedge clk_i);
    #1;
    n_cmp++; if (mispredict_cnt_o !== 16'hFFFF) begin n_fail++; $display("FAIL mis_sat_70000: got %h expected ffff", mispredict_cnt_o); end
    // Asynchronous reset mid-stream, away from any clock edge.
    pc_i = 32'h0000_0040;
    #2;
    rst_ni = 1'b0;
    #1;
    n_cmp++; if (mispredict_cnt_o !== 16'h0) begin n_fail++; $display("FAIL async_rst_cnt: got %h expected 0000", mispredict_cnt_o); end
    n_cmp++; if (predict_idx_o !== 6'h10) begin n_fail++; $display("FAIL async_rst_ghr: idx got %h expected 10", predict_idx_o); end
    pc_i = 32'h0000_00FC;
    #1;
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_pht63: got %b expected 0", predict_taken_o); end
    pc_i = 32'h0000_0014;
    #1;
    n_cmp++; if (predict_taken_o !== 1'b0) begin n_fail++; $display("FAIL async_rst_pht5: got %b expected 0", predict_taken_o); end
    update_valid_i = 1'b0; update_mispredict_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_ghr();
    test_same_index();
    test_mispredict();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
